column_drawer: RTL

COLUMN_DRAWER -- requirements
Module: column_drawer

---
 rtl/doom58_pkg.sv | 22 ++
 rtl/column_drawer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/doom58_pkg.sv
// Screen geometry, palette constants and state encoding shared by the
// main controller and the column drawer.
package doom58_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] CEIL_COLOUR  = 3'b001;
  localparam logic [2:0] FLOOR_COLOUR = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } draw_state_e;

  // First wall row for a height already clamped to the screen height.
  function automatic logic [7:0] wall_top(input logic [7:0] h, input logic [7:0] screen_h);
    return (screen_h - h) >> 1;
  endfunction

endpackage

// File: rtl/column_drawer.sv
// Paints one vertical framebuffer column (ceiling / wall / floor) through the
// VGA adapter pixel-write port, one registered pixel per clock.
module column_drawer #(
  parameter int         SCREEN_W     = doom58_pkg::SCREEN_W,
  parameter int         SCREEN_H     = doom58_pkg::SCREEN_H,
  parameter logic [2:0] CEIL_COLOUR  = doom58_pkg::CEIL_COLOUR,
  parameter logic [2:0] FLOOR_COLOUR = doom58_pkg::FLOOR_COLOUR
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] col_x,
  input  logic [6:0] wall_h,
  input  logic [2:0] wall_colour,
  output logic       ready,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_write
);

  localparam logic [7:0] SCREEN_W8 = 8'(SCREEN_W);
  localparam logic [7:0] SCREEN_H8 = 8'(SCREEN_H);
  localparam logic [6:0] LAST_ROW  = 7'(SCREEN_H - 1);

  doom58_pkg::draw_state_e state_q;

  logic [6:0] y_q;
  logic [7:0] top_q;
  logic [7:0] bottom_q;
  logic [2:0] wall_colour_q;
  logic       ready_q;
  logic       done_q;
  logic       vga_write_q;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] vga_colour_q;

  logic [7:0] h_d;
  logic [7:0] top_d;
  logic [7:0] bottom_d;
  logic [6:0] y_d;
  logic [2:0] first_colour_d;
  logic [2:0] next_colour_d;

  function automatic logic [2:0] row_colour(input logic [6:0] row, input logic [7:0] top,
                                            input logic [7:0] bottom, input logic [2:0] wall_c);
    if ({1'b0, row} < top)
      return CEIL_COLOUR;
    else if ({1'b0, row} < bottom)
      return wall_c;
    else
      return FLOOR_COLOUR;
  endfunction

  // Geometry is taken from the raw inputs, so it only matters on the accepting edge.
  always_comb begin
    h_d            = ({1'b0, wall_h} < SCREEN_H8) ? {1'b0, wall_h} : SCREEN_H8;
    top_d          = doom58_pkg::wall_top(h_d, SCREEN_H8);
    bottom_d       = top_d + h_d;
    y_d            = y_q + 7'd1;
    first_colour_d = row_colour(7'd0, top_d, bottom_d, wall_colour);
    next_colour_d  = row_colour(y_d, top_q, bottom_q, wall_colour_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= doom58_pkg::ST_IDLE;
      y_q           <= '0;
      top_q         <= '0;
      bottom_q      <= '0;
      wall_colour_q <= '0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      vga_write_q   <= 1'b0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
    end else begin
      case (state_q)
        doom58_pkg::ST_IDLE: begin
          if (start) begin
            ready_q       <= 1'b0;
            y_q           <= '0;
            top_q         <= top_d;
            bottom_q      <= bottom_d;
            wall_colour_q <= wall_colour;
            if (col_x < SCREEN_W8) begin
              // Row 0 is presented straight away so the column needs exactly SCREEN_H cycles.
              state_q      <= doom58_pkg::ST_DRAW;
              vga_write_q  <= 1'b1;
              vga_x_q      <= col_x;
              vga_y_q      <= '0;
              vga_colour_q <= first_colour_d;
            end else begin
              state_q <= doom58_pkg::ST_FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        doom58_pkg::ST_DRAW: begin
          if (y_q == LAST_ROW) begin
            state_q     <= doom58_pkg::ST_FINISH;
            vga_write_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            y_q          <= y_d;
            vga_y_q      <= y_d;
            vga_colour_q <= next_colour_d;
          end
        end
        doom58_pkg::ST_FINISH: begin
          state_q <= doom58_pkg::ST_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= doom58_pkg::ST_IDLE;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign vga_write  = vga_write_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;

endmodule
